// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the execute-stage ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADDU = 4'b0000;
  localparam alu_op_t OP_ADDS = 4'b0001;
  localparam alu_op_t OP_AND  = 4'b0010;
  localparam alu_op_t OP_OR   = 4'b0011;
  localparam alu_op_t OP_XOR  = 4'b0100;
  localparam alu_op_t OP_NOR  = 4'b0101;
  localparam alu_op_t OP_SLL  = 4'b0110;
  localparam alu_op_t OP_SRL  = 4'b0111;
  localparam alu_op_t OP_SRA  = 4'b1000;
  localparam alu_op_t OP_PASS = 4'b1001;

  typedef struct packed {
    logic cout;
    logic v;
    logic lt;
    logic eq;
    logic gt;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the issuing stage (master) and the ALU (slave).
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Cin;
  alu_op_t          opcod;
  logic [WIDTH-1:0] out;
  logic             Cout;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             V;

  modport master (output X, Y, Cin, opcod, input out, Cout, lt, eq, gt, V);
  modport slave  (input X, Y, Cin, opcod, output out, Cout, lt, eq, gt, V);
endinterface

// File: rtl/alu_core.sv
// Combinational result and flag generation; no state.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] res_o,
  output alu_flags_t       flags_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [3:0]       shamt;
  logic             lt_u, gt_u, lt_s, gt_s, eq_x;

  // Subtract reuses the adder: X + ~Y + 1, with Cin supplying the +1.
  assign b_eff = (op_i == OP_ADDS && cin_i) ? ~y_i : y_i;
  assign sum   = {1'b0, x_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
  assign ovf   = (x_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != x_i[WIDTH-1]);
  assign shamt = y_i[3:0];

  assign eq_x = (x_i == y_i);
  assign lt_u = (x_i < y_i);
  assign gt_u = (x_i > y_i);
  assign lt_s = ($signed(x_i) < $signed(y_i));
  assign gt_s = ($signed(x_i) > $signed(y_i));

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    case (op_i)
      OP_ADDU: begin
        res_o        = sum[WIDTH-1:0];
        flags_o.cout = sum[WIDTH];
      end
      OP_ADDS: begin
        res_o        = sum[WIDTH-1:0];
        flags_o.cout = sum[WIDTH];
        flags_o.v    = ovf;
      end
      OP_AND:  res_o = x_i & y_i;
      OP_OR:   res_o = x_i | y_i;
      OP_XOR:  res_o = x_i ^ y_i;
      OP_NOR:  res_o = ~(x_i | y_i);
      OP_SLL:  res_o = x_i << shamt;
      OP_SRL:  res_o = x_i >> shamt;
      OP_SRA:  res_o = $signed(x_i) >>> shamt;
      OP_PASS: res_o = x_i;
      default: res_o = '0;
    endcase

    // Reserved opcodes leave every flag clear, including the compare.
    if (op_i <= OP_PASS) begin
      flags_o.eq = eq_x;
      flags_o.lt = (op_i == OP_ADDS) ? lt_s : lt_u;
      flags_o.gt = (op_i == OP_ADDS) ? gt_s : gt_u;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: core results captured on each rising edge, cleared by async reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave alu_bus
);

  logic [WIDTH-1:0] res_d, res_q;
  alu_flags_t       flags_d, flags_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x_i     (alu_bus.X),
    .y_i     (alu_bus.Y),
    .cin_i   (alu_bus.Cin),
    .op_i    (alu_bus.opcod),
    .res_o   (res_d),
    .flags_o (flags_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign alu_bus.out  = res_q;
  assign alu_bus.Cout = flags_q.cout;
  assign alu_bus.V    = flags_q.v;
  assign alu_bus.lt   = flags_q.lt;
  assign alu_bus.eq   = flags_q.eq;
  assign alu_bus.gt   = flags_q.gt;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops against an arithmetic model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_if #(.WIDTH(W)) bus_if ();

  alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        cout;
    logic        v;
    logic        lt;
    logic        eq;
    logic        gt;
  } exp_t;

  exp_t prev_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference computed on plain integers: mathematical sums, ranges and ordering.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic cin, input logic [3:0] op);
    exp_t e;
    int ux, uy, sx, sy, r, sh;
    e  = '0;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = int'(y[3:0]);
    r  = 0;
    if (op > 4'd9) return e;
    case (op)
      4'd0: begin
        r      = ux + uy + int'(cin);
        e.cout = (r >= 65536);
      end
      4'd1: begin
        if (cin) begin
          r      = sx - sy;
          e.cout = (ux >= uy);
        end else begin
          r      = sx + sy;
          e.cout = (ux + uy >= 65536);
        end
        e.v = (r > 32767) || (r < -32768);
      end
      4'd2: r = ux & uy;
      4'd3: r = ux | uy;
      4'd4: r = ux ^ uy;
      4'd5: r = ~(ux | uy);
      4'd6: r = ux << sh;
      4'd7: r = ux >> sh;
      4'd8: r = sx >>> sh;
      default: r = ux;
    endcase
    e.out = r[15:0];
    if (op == 4'd1) begin
      e.lt = sx < sy; e.eq = sx == sy; e.gt = sx > sy;
    end else begin
      e.lt = ux < uy; e.eq = ux == uy; e.gt = ux > uy;
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.out  = bus_if.out;
    o.cout = bus_if.Cout;
    o.v    = bus_if.V;
    o.lt   = bus_if.lt;
    o.eq   = bus_if.eq;
    o.gt   = bus_if.gt;
    return o;
  endfunction

  // Drive operands mid-cycle, confirm outputs still hold the previous result,
  // then check the new result one edge later.
  task automatic apply(input logic [15:0] x, input logic [15:0] y,
                       input logic cin, input logic [3:0] op);
    exp_t e;
    bus_if.X     = x;
    bus_if.Y     = y;
    bus_if.Cin   = cin;
    bus_if.opcod = op;
    #1;
    chk("hold_before_edge", 32'(observed()), 32'(prev_exp));
    @(posedge clk);
    #1;
    e = model(x, y, cin, op);
    chk($sformatf("op%0h_out", op), 32'(bus_if.out), 32'(e.out));
    chk($sformatf("op%0h_flags", op), {27'd0, bus_if.Cout, bus_if.V, bus_if.lt, bus_if.eq, bus_if.gt},
        {27'd0, e.cout, e.v, e.lt, e.eq, e.gt});
    prev_exp = e;
  endtask

  initial begin
    logic [15:0] rx, ry;
    prev_exp     = '0;
    rst_n        = 1'b0;
    bus_if.X     = '0;
    bus_if.Y     = '0;
    bus_if.Cin   = 1'b0;
    bus_if.opcod = OP_ADDU;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Make outputs nonzero, then reset between edges.
    apply(16'd5, 16'd3, 1'b0, OP_ADDU);
    chk("pre_reset_out", 32'(bus_if.out), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_all", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_held_over_edge", 32'(observed()), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_exp = '0;

    apply(16'd1, 16'd2, 1'b0, OP_ADDU);
    chk("first_after_reset", {16'd0, bus_if.out}, 32'd3);
    chk("first_after_reset_lt", 32'(bus_if.lt), 32'd1);

    apply(16'd200, 16'd300, 1'b1, OP_ADDU);
    chk("addu_cin", 32'(bus_if.out), 32'd501);
    apply(16'd300, 16'hFFFB, 1'b0, OP_ADDU);
    chk("addu_carry", {bus_if.Cout, bus_if.V, bus_if.out}, {2'b10, 16'd295});

    apply(16'd300, 16'd200, 1'b0, OP_ADDS);
    chk("adds_500", {bus_if.gt, bus_if.out}, {1'b1, 16'd500});
    apply(16'd300, 16'd200, 1'b1, OP_ADDS);
    chk("subs_100", {bus_if.Cout, bus_if.out}, {1'b1, 16'd100});
    apply(16'd3, 16'd3, 1'b1, OP_ADDS);
    chk("subs_eq", {bus_if.eq, bus_if.out}, {1'b1, 16'd0});
    apply(16'h8000, 16'd1, 1'b1, OP_ADDS);
    chk("subs_ovf", {bus_if.V, bus_if.lt, bus_if.out}, {2'b11, 16'h7FFF});
    apply(16'h7FFF, 16'd1, 1'b0, OP_ADDS);
    chk("adds_ovf", {bus_if.V, bus_if.out}, {1'b1, 16'h8000});

    apply(16'h5AEE, 16'hF0FC, 1'b0, OP_AND);
    chk("and", 32'(bus_if.out), 32'h50EC);
    apply(16'h5AEE, 16'hF0FC, 1'b1, OP_OR);
    chk("or", 32'(bus_if.out), 32'hFAFE);
    apply(16'h5AEE, 16'hF0FC, 1'b0, OP_XOR);
    chk("xor", 32'(bus_if.out), 32'hAA12);
    apply(16'h8888, 16'hFFFF, 1'b0, OP_AND);
    chk("and2", 32'(bus_if.out), 32'h8888);
    apply(16'h8888, 16'hFFFF, 1'b1, OP_OR);
    chk("or2_cv", {bus_if.Cout, bus_if.V, bus_if.out}, {2'b00, 16'hFFFF});

    apply(16'h8001, 16'd4, 1'b0, OP_SLL);
    chk("sll", 32'(bus_if.out), 32'h0010);
    apply(16'h8001, 16'd4, 1'b0, OP_SRL);
    chk("srl", 32'(bus_if.out), 32'h0800);
    apply(16'h8001, 16'd4, 1'b0, OP_SRA);
    chk("sra", 32'(bus_if.out), 32'hF800);
    apply(16'h1234, 16'h1234, 1'b1, 4'b1111);
    chk("reserved", 32'(observed()), 32'd0);

    // Back-to-back across opcodes 0..3, one new operand set per cycle.
    for (int i = 0; i < 8; i++)
      apply(16'(($urandom)), 16'($urandom), 1'($urandom), 4'(i % 4));

    for (int i = 0; i < 400; i++) begin
      rx = 16'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? rx : 16'($urandom);
      apply(rx, ry, 1'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit registered arithmetic/logic unit for the execute stage of the pipelined MIPS-style datapath.
- Combinational core computes result, carry, signed overflow and X-versus-Y compare flags from a 4-bit opcode.
- All outputs are captured in an output register, so results appear one clock after the operands are presented.

Parameters:
- WIDTH, 16, operand and result width. All behaviour below is for 16; must scale for any WIDTH ≥ 8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- X  in  WIDTH  operand A
- Y  in  WIDTH  operand B
- Cin  in  1  carry-in; for opcode 0001, selects subtract
- opcod  in  4  operation select
- out  out  WIDTH  registered result
- Cout  out  1  registered carry-out
- lt  out  1  registered X<Y
- eq  out  1  registered X==Y
- gt  out  1  registered X>Y
- V  out  1  registered signed overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: rst_n=0 immediately forces out=0, Cout=0, lt=0, eq=0, gt=0, V=0, independent of clk.
- Reset mid-operation discards the pending result. The first valid output is from the first rising edge after rst_n deasserts.
- Latency: X, Y, Cin and opcod are sampled at a rising edge; the result is visible on the outputs after that same edge. There is no handshake and the unit accepts new operands every cycle.
- 0000, unsigned add: {Cout,out} = X + Y + Cin (17-bit sum). V=0.
- 0001, signed add/sub:
  - Cin=0: out = X + Y; Cout = carry out.
  - Cin=1: out = X + ~Y + 1, i.e. X−Y; Cout = carry out (1 means no borrow).
  - V=1 when operands of the effective addition have the same sign and the result sign differs from them.
- 0010: out = X & Y
- 0011: out = X | Y
- 0100: out = X ^ Y
- 0101: out = ~(X | Y)
- 0110: out = X << Y[3:0] (logical left)
- 0111: out = X >> Y[3:0] (logical right)
- 1000: out = X >>> Y[3:0] (arithmetic right)
- 1001: out = X (pass-through)
- 1010–1111: out = 0, all flags 0 (reserved).
- Cout and V are 0 for every opcode other than 0000 and 0001.
- Compare flags, for opcodes 0000–1001:
  - exactly one of lt, eq, gt is 1.
  - opcode 0001 uses a two's-complement signed comparison.
  - all other defined opcodes use an unsigned comparison.
  - Cin never affects the compare.
- Arithmetic wraps modulo 2^WIDTH. Carry is reported only via Cout; no saturation.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADDU=4'b0000, OP_ADDS=4'b0001, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_PASS
  - a typedef alu_op_t.
- One natural sub-module, alu_core: purely combinational result and flag logic. The top level alu adds only the output register with async reset.

Test Plan:
- Reset: assert rst_n=0 between edges with nonzero outputs → all outputs 0 immediately. Release, then X=1, Y=2, opcod=0000, Cin=0 → after next edge out=3, Cout=0, lt=1.
- Unsigned add: X=200, Y=300, Cin=1, op=0000 → out=501, Cout=0, lt=1. X=300, Y=16'hFFFB, Cin=0 → out=295, Cout=1, lt=1, V=0.
- Signed add/sub (op=0001):
  - X=300, Y=200, Cin=0 → out=500, gt=1.
  - same with Cin=1 → out=100, Cout=1.
  - X=3, Y=3, Cin=1 → out=0, eq=1.
  - X=16'h8000, Y=1, Cin=1 → out=16'h7FFF, V=1, lt=1.
  - X=16'h7FFF, Y=1, Cin=0 → out=16'h8000, V=1.
- Logic ops: X=16'h5AEE, Y=16'hF0FC → AND gives 16'h50EC, OR gives 16'hFAFE, XOR gives 16'hAA12. X=16'h8888, Y=16'hFFFF → AND gives 16'h8888, OR gives 16'hFFFF. Cout=0 and V=0 throughout.
- Shifts and reserved codes:
  - X=16'h8001, Y=4 → SLL gives 16'h0010, SRL gives 16'h0800, SRA gives 16'hF800.
  - op=1111 → out=0, all flags 0.
- Back-to-back throughput: change operands every cycle across opcodes 0000→0011 → each result appears exactly one edge after its inputs, with no bubbles.
